// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO input-conditioning stage.
//   state_t          : command FSM states
//   DEF_DB_CYCLES    : default debounce length (10 ms at 100 MHz)
//   DEF_GAP_CYCLES   : default idle cycles between commands
//   STROBE_CYCLES    : width of an enqueue/dequeue strobe
package fifo_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PUSH1,
    PUSH2,
    POP1,
    POP2,
    GAP
  } state_t;

  localparam int unsigned DEF_DB_CYCLES  = 1_000_000;
  localparam int unsigned DEF_GAP_CYCLES = 2;
  localparam int unsigned STROBE_CYCLES  = 2;

endpackage

// File: rtl/debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, debounced
// level and a one-cycle pulse on each debounced 0->1 transition.
//   clk, rst : clock, asynchronous active-high reset
//   btn      : raw asynchronous button input
//   level    : debounced button level
//   rise     : high for one cycle after level goes 0->1
module debounce
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_q <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES)) begin
        // Counter sits at DB_CYCLES for one edge before the toggle, so a
        // change must be seen on DB_CYCLES+1 consecutive samples.
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/fifo_input_ctrl.sv
// Input-conditioning stage in front of the 8-entry byte FIFO. Debounces
// the push/pop buttons, turns each clean press into one two-cycle
// enqueue/dequeue strobe, latches the switch byte as write data and
// enforces an idle gap between commands.
//   clk, rst  : clock, asynchronous active-high reset
//   btn_push  : raw enqueue button
//   btn_pop   : raw dequeue button
//   sw        : raw data switches
//   eni       : enqueue strobe (2 cycles)
//   eno       : dequeue strobe (2 cycles)
//   din       : write data, captured on entry to PUSH1
//   busy      : high while a command or gap is in progress
module fifo_input_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = DEF_DB_CYCLES,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_push,
  input  logic       btn_pop,
  input  logic [7:0] sw,
  output logic       eni,
  output logic       eno,
  output logic [7:0] din,
  output logic       busy
);

  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  logic          push_level;
  logic          push_rise;
  logic          pop_level;
  logic          pop_rise;
  logic          pend_push;
  logic          pend_pop;
  logic          push_req;
  logic          pop_req;
  logic [GW-1:0] gap_cnt;
  state_t        state;

  debounce #(.DB_CYCLES(DB_CYCLES)) u_db_push (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_push),
    .level (push_level),
    .rise  (push_rise)
  );

  debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pop (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_pop),
    .level (pop_level),
    .rise  (pop_rise)
  );

  // A rise arriving this cycle is served as if already pending, so an idle
  // controller starts the command on the edge after the debounced toggle.
  assign push_req = pend_push | push_rise;
  assign pop_req  = pend_pop  | pop_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pend_push <= 1'b0;
      pend_pop  <= 1'b0;
      gap_cnt   <= '0;
      din       <= '0;
      eni       <= 1'b0;
      eno       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      pend_push <= push_req;
      pend_pop  <= pop_req;
      case (state)
        IDLE: begin
          if (push_req) begin
            state     <= PUSH1;
            pend_push <= 1'b0;
            din       <= sw;
            eni       <= 1'b1;
            busy      <= 1'b1;
          end else if (pop_req) begin
            state    <= POP1;
            pend_pop <= 1'b0;
            eno      <= 1'b1;
            busy     <= 1'b1;
          end
        end
        PUSH1: state <= PUSH2;
        PUSH2: begin
          state   <= GAP;
          eni     <= 1'b0;
          gap_cnt <= '0;
        end
        POP1: state <= POP2;
        POP2: begin
          state   <= GAP;
          eno     <= 1'b0;
          gap_cnt <= '0;
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          state <= IDLE;
          eni   <= 1'b0;
          eno   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_input_ctrl.sv
// Self-checking bench for fifo_input_ctrl with DB_CYCLES=4, GAP_CYCLES=2.
module tb_fifo_input_ctrl;

  localparam int DB  = 4;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_push = 1'b0;
  logic       btn_pop = 1'b0;
  logic [7:0] sw = '0;
  logic       eni;
  logic       eno;
  logic [7:0] din;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fifo_input_ctrl #(.DB_CYCLES(DB), .GAP_CYCLES(GAP)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_push (btn_push),
    .btn_pop  (btn_pop),
    .sw       (sw),
    .eni      (eni),
    .eno      (eno),
    .din      (din),
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Raw button samples are kept per edge since reset. A debounced level
  // flips at edge k when the synchronized view (raw delayed by 2 edges) has
  // disagreed with it on DB+1 consecutive edges, none earlier than the
  // previous flip. A command occupies edges s..s+1 (strobe) and s+2..s+1+GAP.
  bit  hp[$];
  bit  hq[$];
  int  m_k = 0;
  bit  lvl_p = 0, lvl_q = 0;
  int  lt_p = -1, lt_q = -1;
  int  rise_p = -1000, rise_q = -1000;
  bit  pend_p = 0, pend_q = 0;
  int  m_s = -1000;
  bit  m_kind = 0;
  logic [7:0] m_din = '0;

  function automatic bit flips(input bit q[$], input int k, input bit lvl, input int last);
    if (k - DB < last + 1) return 1'b0;
    for (int j = 0; j <= DB; j++) begin
      int i;
      bit v;
      i = k - 2 - j;
      v = (i >= 0) ? q[i] : 1'b0;
      if (v == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hp.delete();
      hq.delete();
      m_k = 0;
      lvl_p = 0; lvl_q = 0;
      lt_p = -1; lt_q = -1;
      rise_p = -1000; rise_q = -1000;
      pend_p = 0; pend_q = 0;
      m_s = -1000;
      m_kind = 0;
      m_din = '0;
    end else begin
      hp.push_back(btn_push);
      hq.push_back(btn_pop);
      if (rise_p == m_k - 1) pend_p = 1;
      if (rise_q == m_k - 1) pend_q = 1;
      if (m_k >= m_s + 3 + GAP) begin
        if (pend_p) begin
          m_s = m_k; m_kind = 1; m_din = sw; pend_p = 0;
        end else if (pend_q) begin
          m_s = m_k; m_kind = 0; pend_q = 0;
        end
      end
      if (flips(hp, m_k, lvl_p, lt_p)) begin
        lvl_p = ~lvl_p; lt_p = m_k;
        if (lvl_p) rise_p = m_k;
      end
      if (flips(hq, m_k, lvl_q, lt_q)) begin
        lvl_q = ~lvl_q; lt_q = m_k;
        if (lvl_q) rise_q = m_k;
      end
      m_k++;
    end
  end

  always @(negedge clk) begin
    int e;
    bit str, bsy;
    e   = m_k - 1;
    str = (e >= m_s) && (e <= m_s + 1);
    bsy = (e >= m_s) && (e <= m_s + 1 + GAP);
    chk("eni",  {7'b0, eni},  {7'b0, str && m_kind});
    chk("eno",  {7'b0, eno},  {7'b0, str && !m_kind});
    chk("busy", {7'b0, busy}, {7'b0, bsy});
    chk("din",  din, m_din);
  end

  int eni_rises = 0;
  logic eni_d = 1'b0;
  always @(negedge clk) begin
    if (eni && !eni_d) eni_rises++;
    eni_d = eni;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int eno_seen;
    tick(3);
    chk("rst_eni", {7'b0, eni}, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    tick(3);

    // clean push held 20 cycles
    sw = 8'hA5;
    eni_rises = 0;
    btn_push = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick(1);
      if (t == 7 || t == 10) chk("t1_eni_lo", {7'b0, eni}, 8'h00);
      if (t == 8 || t == 9)  chk("t1_eni_hi", {7'b0, eni}, 8'h01);
      if (t == 8 || t == 20) chk("t1_din", din, 8'hA5);
    end
    chk("t1_one_strobe", eni_rises[7:0], 8'd1);
    btn_push = 1'b0;
    tick(15);

    // bouncy pop
    eno_seen = 0;
    for (int i = 0; i < 10; i++) begin
      btn_pop = ((i / 2) % 2 == 1);
      tick(1);
      if (eno) eno_seen++;
    end
    chk("t2_no_eno_bounce", eno_seen[7:0], 8'd0);
    btn_pop = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick(1);
      if (t == 7 || t == 10) chk("t2_eno_lo", {7'b0, eno}, 8'h00);
      if (t == 8 || t == 9)  chk("t2_eno_hi", {7'b0, eno}, 8'h01);
    end
    chk("t2_din_kept", din, 8'hA5);
    btn_pop = 1'b0;
    tick(15);

    // both buttons in the same cycle
    sw = 8'h11;
    btn_push = 1'b1;
    btn_pop  = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      tick(1);
      if (t == 8 || t == 9)   chk("t3_eni", {6'b0, eni, eno}, 8'h02);
      if (t >= 10 && t <= 12) chk("t3_gap", {6'b0, eni, eno}, 8'h00);
      if (t == 13 || t == 14) chk("t3_eno", {6'b0, eni, eno}, 8'h01);
    end
    btn_push = 1'b0;
    btn_pop  = 1'b0;
    tick(15);

    // pop pressed during push strobe, sw changes mid-push
    sw = 8'h5A;
    btn_push = 1'b1;
    tick(8);
    chk("t4_eni", {7'b0, eni}, 8'h01);
    btn_pop = 1'b1;
    sw = 8'h3C;
    for (int t = 1; t <= 10; t++) begin
      tick(1);
      if (t == 1) chk("t4_din_push2", din, 8'h5A);
      if (t == 8 || t == 9) chk("t4_eno", {7'b0, eno}, 8'h01);
      if (t == 9) chk("t4_din_pop", din, 8'h5A);
    end
    btn_push = 1'b0;
    btn_pop  = 1'b0;
    tick(15);

    // reset during PUSH2
    sw = 8'h77;
    btn_push = 1'b1;
    tick(9);
    chk("t5_eni_push2", {7'b0, eni}, 8'h01);
    #1;
    rst = 1'b1;
    btn_push = 1'b0;
    #1;
    chk("t5_eni_rst", {7'b0, eni}, 8'h00);
    chk("t5_busy_rst", {7'b0, busy}, 8'h00);
    chk("t5_din_rst", din, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    eni_rises = 0;
    tick(20);
    chk("t5_no_reissue", eni_rises[7:0], 8'd0);

    // three pushes debounced 10 cycles apart
    eni_rises = 0;
    for (int r = 0; r < 3; r++) begin
      sw = 8'(8'h20 + r);
      btn_push = 1'b1;
      tick(5);
      btn_push = 1'b0;
      tick(5);
    end
    tick(20);
    chk("t6_three_pushes", eni_rises[7:0], 8'd3);
    chk("t6_din_last", din, 8'h22);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
